// File: rtl/not_gate_core.sv
// Parameterized masked inverter: a combinational a ^ INV_MASK path, plus a registered
// copy with a load enable and valid flag, and a saturating counter of output toggles.
module not_gate_core #(
    parameter int unsigned         WIDTH    = 1,
    parameter int unsigned         CNT_W    = 16,
    parameter logic [WIDTH-1:0]    INV_MASK = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic             en,
    input  logic             clr_cnt,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q,
    output logic             y_q_valid,
    output logic [CNT_W-1:0] toggle_cnt
);

    logic [WIDTH-1:0] y_reg_q, y_reg_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] y_prev_q, y_prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             toggled;
    logic             cnt_sat;

    // The main path stays purely combinational so it works with no clock at all.
    assign y = a ^ INV_MASK;

    always_comb begin
        y_reg_d  = y_reg_q;
        valid_d  = valid_q;
        y_prev_d = y;
        cnt_d    = cnt_q;
        toggled  = |(y ^ y_prev_q);
        cnt_sat  = &cnt_q;

        if (en) begin
            y_reg_d = y;
            valid_d = 1'b1;
        end

        // Clear wins over increment; the counter holds at all-ones instead of wrapping.
        if (clr_cnt) begin
            cnt_d = '0;
        end else if (toggled && !cnt_sat) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_reg_q  <= '0;
            valid_q  <= 1'b0;
            y_prev_q <= '0;
            cnt_q    <= '0;
        end else begin
            y_reg_q  <= y_reg_d;
            valid_q  <= valid_d;
            y_prev_q <= y_prev_d;
            cnt_q    <= cnt_d;
        end
    end

    assign y_q        = y_reg_q;
    assign y_q_valid  = valid_q;
    assign toggle_cnt = cnt_q;

endmodule

// File: tb/tb_not_gate_core.sv
// Directed bench for not_gate_core: default 1-bit cell, a 2-bit-counter cell for
// saturation, and an 8-bit cell with a partial inversion mask.
module tb_not_gate_core;

    logic clk;
    logic rst_n;

    logic        a1, en1, clr1;
    logic        y1, yq1, v1;
    logic [15:0] cnt1;

    logic        a2, en2, clr2;
    logic        y2, yq2, v2;
    logic [1:0]  cnt2;

    logic [7:0]  a3, y3, yq3;
    logic        en3, clr3, v3;
    logic [15:0] cnt3;

    int passed;
    int total;

    not_gate_core u1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .en(en1), .clr_cnt(clr1),
        .y(y1), .y_q(yq1), .y_q_valid(v1), .toggle_cnt(cnt1)
    );

    not_gate_core #(.WIDTH(1), .CNT_W(2)) u2 (
        .clk(clk), .rst_n(rst_n), .a(a2), .en(en2), .clr_cnt(clr2),
        .y(y2), .y_q(yq2), .y_q_valid(v2), .toggle_cnt(cnt2)
    );

    not_gate_core #(.WIDTH(8), .CNT_W(16), .INV_MASK(8'h0F)) u3 (
        .clk(clk), .rst_n(rst_n), .a(a3), .en(en3), .clr_cnt(clr3),
        .y(y3), .y_q(yq3), .y_q_valid(v3), .toggle_cnt(cnt3)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic a;
        logic en;
        logic clr;
        logic exp_y;
        logic exp_yq;
        logic exp_v;
        int   exp_cnt;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end else begin
            passed++;
        end
    endtask

    initial begin
        passed = 0;
        total  = 0;

        vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2};

        rst_n = 1'b0;
        a1 = 1'b0; en1 = 1'b0; clr1 = 1'b0;
        a2 = 1'b0; en2 = 1'b0; clr2 = 1'b0;
        a3 = 8'hA5; en3 = 1'b0; clr3 = 1'b0;

        // combinational path and reset state
        #1;
        chk("y1_a0", 64'(y1), 64'h1);
        chk("y3_a5", 64'(y3), 64'hAA);
        chk("rst_yq1", 64'(yq1), 64'h0);
        chk("rst_v1", 64'(v1), 64'h0);
        chk("rst_cnt1", 64'(cnt1), 64'h0);
        #9 a1 = 1'b1;
        #1;
        chk("y1_a1", 64'(y1), 64'h0);

        @(negedge clk);
        rst_n = 1'b1;

        // table-driven registered path and toggle counter
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            a1 = vecs[i].a; en1 = vecs[i].en; clr1 = vecs[i].clr;
            #1;
            chk($sformatf("v%0d_y", i), 64'(y1), 64'(vecs[i].exp_y));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_yq", i), 64'(yq1), 64'(vecs[i].exp_yq));
            chk($sformatf("v%0d_valid", i), 64'(v1), 64'(vecs[i].exp_v));
            chk($sformatf("v%0d_cnt", i), 64'(cnt1), 64'(vecs[i].exp_cnt));
        end

        // asynchronous reset between edges while y_q = 1
        en1 = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_yq1", 64'(yq1), 64'h0);
        chk("arst_v1", 64'(v1), 64'h0);
        chk("arst_cnt1", 64'(cnt1), 64'h0);
        chk("arst_y1", 64'(y1), 64'h1);
        a1 = 1'b1;
        #1;
        chk("arst_y1_follow", 64'(y1), 64'h0);

        // saturation on the 2-bit counter and the masked 8-bit cell
        @(negedge clk);
        a2 = 1'b0; en2 = 1'b0;
        a3 = 8'hA5; en3 = 1'b1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("sat%0d_cnt2", i), 64'(cnt2), 64'((i + 1 > 3) ? 3 : i + 1));
            chk($sformatf("sat%0d_v2", i), 64'(v2), 64'h0);
            if (i == 0) begin
                chk("w8_yq", 64'(yq3), 64'hAA);
                chk("w8_valid", 64'(v3), 64'h1);
                chk("w8_cnt", 64'(cnt3), 64'h1);
                en3 = 1'b0;
                a3 = 8'h00;
                #1;
                chk("w8_y_00", 64'(y3), 64'h0F);
            end else if (i == 1) begin
                chk("w8_yq_hold", 64'(yq3), 64'hAA);
                chk("w8_cnt2", 64'(cnt3), 64'h2);
                a3 = 8'hFF;
                #1;
                chk("w8_y_ff", 64'(y3), 64'hF0);
            end
            @(negedge clk);
            a2 = ~a2;
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/not_gate_core.md
Name:
not_gate_core

Overview:
- Parameterized bitwise inverter cell for the logic-gate library.
- Primary path: combinational `y = ~a`, with zero latency and no clock dependence.
- Secondary registered path: a clocked copy of the inverted output with enable and valid flag, plus a saturating output-toggle counter for coverage/activity monitoring.
- Default configuration (WIDTH=1) behaves as a plain single-bit NOT gate.

Parameters:
- WIDTH, 1, data width of `a`/`y`/`y_q` (valid 1..64).
- CNT_W, 16, width of the toggle counter.
- INV_MASK, all-ones, bit i = 1 means bit i is inverted; bit i = 0 means bit i passes through unchanged. Applies to both `y` and `y_q`.

Ports:
- clk  input  1  rising-edge clock for the registered path only.
- rst_n  input  1  asynchronous active-low reset.
- a  input  WIDTH  data input.
- en  input  1  registered-path load enable.
- clr_cnt  input  1  synchronous toggle-counter clear.
- y  output  WIDTH  combinational result, `a ^ INV_MASK` (equals `~a` with the default mask).
- y_q  output  WIDTH  registered result.
- y_q_valid  output  1  high once `y_q` has been loaded since reset.
- toggle_cnt  output  CNT_W  count of cycles in which `y` differed from its previous sampled value.

Behaviour:
- Reset is asynchronous and active-low. Clock `clk`, reset `rst_n`.
- `y`:
  - Purely combinational: `y = a ^ INV_MASK`.
  - Unaffected by `clk`, `rst_n`, `en`.
  - Zero delta latency; valid with `clk` undriven.
  - X/Z on `a` bits propagates as X on the corresponding `y` bits.
- `y_q`:
  - `rst_n` low → `y_q = 0`, `y_q_valid = 0`, immediately (no clock needed).
  - Rising `clk` with `en = 1` → `y_q <= a ^ INV_MASK`, `y_q_valid <= 1`.
  - `en = 0` → `y_q` holds; `y_q_valid` holds.
  - One-cycle latency from `a` to `y_q`.
- Toggle counter:
  - Internal register `y_prev` (reset 0) samples `y` every rising `clk`.
  - If `y != y_prev` (any bit) and `clr_cnt = 0`: `toggle_cnt` increments by 1, saturating at all-ones (no wrap).
  - `clr_cnt = 1` → `toggle_cnt <= 0` that cycle. Clear has priority over increment; `y_prev` still updates.
  - Reset → `toggle_cnt = 0`.
  - First edge after reset with `a` such that `y != 0` counts as one toggle.
- Reset mid-operation: all registered outputs clear asynchronously. `y` continues to follow `a` throughout.
- No handshake; `en` is a simple qualifier. Simultaneous `en` and `clr_cnt` are independent.

Test Plan:
- WIDTH=1, default mask, no clock: `a=0` → `y=1`; after 10 ns `a=1` → `y=0`. Check at each step with zero latency.
- Registered path: `rst_n` low → `y_q=0`, `y_q_valid=0`. Release reset, `en=1`, `a=0`, one edge → `y_q=1`, `y_q_valid=1`. Then `en=0`, `a=1` → `y_q` stays 1.
- Asynchronous reset: assert `rst_n` low between clock edges while `y_q=1` → `y_q`, `y_q_valid`, `toggle_cnt` go to 0 immediately; `y` still equals `~a`.
- Toggle counter: alternate `a` 0/1 each cycle for 5 cycles → `toggle_cnt=5`. Assert `clr_cnt` while toggling → `toggle_cnt=0` next cycle.
- Saturation: CNT_W=2, toggle for 6 cycles → `toggle_cnt` stays at 3.
- WIDTH=8, INV_MASK=8'h0F, `a=8'hA5` → `y=8'hAA`; after one enabled edge → `y_q=8'hAA`.
